// File: rtl/fixed_requant_pkg.sv
// fixed_requant_pkg: shared types and round/saturate helpers for the requantiser
package fixed_requant_pkg;

    localparam int LANE_W = 32;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_e;

    typedef struct packed {
        logic signed [LANE_W-1:0] value;
        logic                     clipped;
    } lane_res_t;

    function automatic int calc_shift(input int in_frac, input int out_frac);
        return in_frac - out_frac;
    endfunction

    // Round half toward +inf, then clamp to the signed out_w range.
    // The wide intermediate keeps the rounding add from wrapping.
    function automatic lane_res_t round_sat(
        input logic signed [LANE_W-1:0] x,
        input int                       shift,
        input int                       out_w
    );
        logic signed [LANE_W-1:0] bias, t, hi, lo;
        lane_res_t r;
        bias      = (shift > 0) ? (32'sd1 <<< (shift - 1)) : 32'sd0;
        t         = (x + bias) >>> shift;
        hi        = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo        = -(32'sd1 <<< (out_w - 1));
        r.value   = (t > hi) ? hi : (t < lo) ? lo : t;
        r.clipped = (t > hi) || (t < lo);
        return r;
    endfunction

endpackage

// File: rtl/fixed_round_sat_lane.sv
// fixed_round_sat_lane: combinational round-half-up and saturate for one lane
module fixed_round_sat_lane
    import fixed_requant_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int IN_FRAC  = 3,
    parameter int OUT_W    = 5,
    parameter int OUT_FRAC = 2
) (
    input  logic [IN_W-1:0]  i_data,
    output logic [OUT_W-1:0] o_data,
    output logic             o_clipped
);

    lane_res_t w_res;

    assign w_res     = round_sat(LANE_W'(signed'(i_data)), calc_shift(IN_FRAC, OUT_FRAC), OUT_W);
    assign o_data    = w_res.value[OUT_W-1:0];
    assign o_clipped = w_res.clipped;

    // the clamped value must fit the narrow output word
    always_comb assert (w_res.value == LANE_W'(signed'(w_res.value[OUT_W-1:0])));

endmodule

// File: rtl/fixed_requant_stream.sv
// fixed_requant_stream: requantise parallel signed lanes behind a valid/ready skid buffer
module fixed_requant_stream
    import fixed_requant_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0  = 8,
    parameter int DATA_IN_0_PRECISION_1  = 3,
    parameter int DATA_OUT_0_PRECISION_0 = 5,
    parameter int DATA_OUT_0_PRECISION_1 = 2,
    parameter int PARALLELISM            = 4,
    parameter int SAT_CNT_WIDTH          = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [PARALLELISM*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
    input  logic                                          data_in_0_valid,
    output logic                                          data_in_0_ready,
    output logic [PARALLELISM*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
    output logic                                          data_out_0_valid,
    input  logic                                          data_out_0_ready,
    input  logic                                          sat_clear,
    output logic [SAT_CNT_WIDTH-1:0]                      sat_count
);

    localparam int IN_W   = DATA_IN_0_PRECISION_0;
    localparam int OUT_W  = DATA_OUT_0_PRECISION_0;
    localparam int BEAT_W = PARALLELISM * OUT_W;

    if (DATA_OUT_0_PRECISION_1 > DATA_IN_0_PRECISION_1) begin : g_bad_frac
        $error("output fractional bits exceed input fractional bits");
    end

    logic [BEAT_W-1:0]        w_beat, r_out_data, r_skid_data;
    logic [PARALLELISM-1:0]   w_lane_clip;
    logic                     r_out_valid, r_skid_valid;
    logic                     w_accept, w_drain, w_clipped;
    logic [SAT_CNT_WIDTH-1:0] r_sat;
    skid_state_e              w_state;

    for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
        fixed_round_sat_lane #(
            .IN_W    (IN_W),
            .IN_FRAC (DATA_IN_0_PRECISION_1),
            .OUT_W   (OUT_W),
            .OUT_FRAC(DATA_OUT_0_PRECISION_1)
        ) u_lane (
            .i_data   (data_in_0[i*IN_W +: IN_W]),
            .o_data   (w_beat[i*OUT_W +: OUT_W]),
            .o_clipped(w_lane_clip[i])
        );
    end

    assign w_clipped        = |w_lane_clip;
    assign w_accept         = data_in_0_valid & ~r_skid_valid;
    assign w_drain          = r_out_valid & data_out_0_ready;
    assign data_in_0_ready  = ~r_skid_valid;
    assign data_out_0_valid = r_out_valid;
    assign data_out_0       = r_out_data;
    assign sat_count        = r_sat;
    assign w_state          = r_skid_valid ? FULL : r_out_valid ? ONE : EMPTY;

    // a full buffer must never take a beat
    always_comb if (w_accept) assert (w_state != FULL);

    // occupancy: skid is only ever filled behind a valid, stalled output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            r_skid_valid <= ~w_drain;
        end else if (r_out_valid) begin
            r_out_valid  <= w_accept | ~w_drain;
            r_skid_valid <= w_accept & ~w_drain;
        end else begin
            r_out_valid  <= w_accept;
        end
    end

    // payload: refill output from skid on drain, else land new beats in the free slot
    always_ff @(posedge clk) begin
        if (r_skid_valid) begin
            if (w_drain) r_out_data <= r_skid_data;
        end else if (w_accept & (~r_out_valid | w_drain)) begin
            r_out_data <= w_beat;
        end else if (w_accept) begin
            r_skid_data <= w_beat;
        end
    end

    // sticky count of accepted beats with a clipped lane; clear wins, no wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sat <= '0;
        else if (sat_clear) r_sat <= '0;
        else if (w_accept & w_clipped & ~&r_sat) r_sat <= r_sat + 1'b1;
    end

endmodule

// File: tb/tb_fixed_requant_stream.sv
// tb_fixed_requant_stream: directed and randomised checks against an arithmetic reference
module tb_fixed_requant_stream;

    localparam int IW  = 8;
    localparam int IFR = 3;
    localparam int OW  = 5;
    localparam int OFR = 2;
    localparam int PAR = 4;
    localparam int BW  = PAR * OW;

    logic              clk = 1'b0;
    logic              rst;
    logic [PAR*IW-1:0] din;
    logic              iv, ordy, clr;
    logic              data_in_0_ready, data_out_0_valid;
    logic [BW-1:0]     data_out_0;
    logic [15:0]       sat_count;

    logic [PAR*IW-1:0] s_din;
    logic              s_iv, s_clr, s_irdy, s_ov;
    logic [BW-1:0]     s_dout;
    logic [3:0]        s_cnt;

    int          checks = 0;
    int          failures = 0;
    int          n_acc = 0;
    int          full_seen = 0;
    int          full_to_one = 0;
    bit          prev_full = 0;
    bit          sb_on = 0;
    logic [15:0] model_sat = '0;
    logic [BW-1:0] exp_q[$];
    logic [BW:0]   mon_r;

    always #5 clk = ~clk;

    fixed_requant_stream u_dut (
        .clk(clk), .rst(rst),
        .data_in_0(din), .data_in_0_valid(iv), .data_in_0_ready(data_in_0_ready),
        .data_out_0(data_out_0), .data_out_0_valid(data_out_0_valid), .data_out_0_ready(ordy),
        .sat_clear(clr), .sat_count(sat_count)
    );

    fixed_requant_stream #(.SAT_CNT_WIDTH(4)) u_small (
        .clk(clk), .rst(rst),
        .data_in_0(s_din), .data_in_0_valid(s_iv), .data_in_0_ready(s_irdy),
        .data_out_0(s_dout), .data_out_0_valid(s_ov), .data_out_0_ready(1'b1),
        .sat_clear(s_clr), .sat_count(s_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: real-valued round half up of x/2^shift, then clamp; returns {clipped, lanes}
    function automatic logic [BW:0] ref_beat(input logic [PAR*IW-1:0] d);
        logic [BW:0] r = '0;
        for (int k = 0; k < PAR; k++) begin
            logic signed [IW-1:0] x;
            int t;
            x = d[k*IW +: IW];
            t = int'($floor(real'(x) / (2.0 ** (IFR - OFR)) + 0.5));
            if (t > 2 ** (OW - 1) - 1) begin
                t = 2 ** (OW - 1) - 1;
                r[BW] = 1'b1;
            end else if (t < -(2 ** (OW - 1))) begin
                t = -(2 ** (OW - 1));
                r[BW] = 1'b1;
            end
            r[k*OW +: OW] = t[OW-1:0];
        end
        return r;
    endfunction

    // scoreboard: observe handshakes mid-cycle, values are stable until the next edge
    always @(negedge clk) begin
        if (sb_on) begin
            check("sat_count", 32'(sat_count), 32'(model_sat));
            if (data_out_0_valid && ordy) begin
                check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("beat_data", 32'(data_out_0), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
            if (iv && data_in_0_ready) begin
                mon_r = ref_beat(din);
                exp_q.push_back(mon_r[BW-1:0]);
                n_acc++;
                if (!clr && mon_r[BW] && model_sat != 16'hFFFF) model_sat++;
            end
            if (clr) model_sat = '0;
            if (!data_in_0_ready) full_seen++;
            if (prev_full && data_in_0_ready && data_out_0_valid) full_to_one++;
        end
        prev_full = sb_on && !data_in_0_ready;
    end

    initial begin
        int cnt;
        bit acc;
        rst = 1; iv = 0; ordy = 0; clr = 0; din = '0;
        s_iv = 0; s_clr = 0; s_din = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(data_out_0_valid), 32'd0);
        check("rst_in_ready", 32'(data_in_0_ready), 32'd1);
        check("rst_sat_count", 32'(sat_count), 32'd0);
        rst = 0;
        sb_on = 1;

        // in-range rounding, lanes {1,0,-3,5}
        din = 32'h0100FD05; iv = 1; ordy = 1;
        tick();
        check("rnd_valid", 32'(data_out_0_valid), 32'd1);
        check("rnd_data", 32'(data_out_0), 32'({5'd1, 5'd0, 5'b11111, 5'd3}));
        // clipping lanes {-128,127,-100,40}
        din = 32'h807F9C28;
        tick();
        check("clip_data", 32'(data_out_0), 32'({5'b10000, 5'b01111, 5'b10000, 5'b01111}));
        check("clip_sat", 32'(sat_count), 32'd1);
        iv = 0;
        tick();
        check("drained", 32'(data_out_0_valid), 32'd0);

        // backpressure: ready drops after one extra beat
        ordy = 0; iv = 1; din = $urandom();
        tick();
        check("bp_ready_one", 32'(data_in_0_ready), 32'd1);
        din = $urandom();
        tick();
        check("bp_ready_full", 32'(data_in_0_ready), 32'd0);
        din = $urandom();
        tick();
        check("bp_ready_held", 32'(data_in_0_ready), 32'd0);
        check("bp_valid_held", 32'(data_out_0_valid), 32'd1);
        ordy = 1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            acc = data_in_0_ready;
            tick();
            cnt += int'(data_out_0_valid);
            if (acc) din = $urandom();
        end
        check("bp_throughput", 32'(cnt), 32'd8);
        iv = 0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        check("bp_all_delivered", 32'(exp_q.size()), 32'd0);

        // counter saturation on a 4-bit counter instance
        s_din = 32'h7F7F7F7F; s_iv = 1;
        repeat (15) tick();
        check("sat_reach_max", 32'(s_cnt), 32'hF);
        tick();
        check("sat_hold_max", 32'(s_cnt), 32'hF);
        s_clr = 1;
        tick();
        check("sat_clear_wins", 32'(s_cnt), 32'd0);
        s_clr = 0;
        tick();
        check("sat_after_clear", 32'(s_cnt), 32'd1);
        s_iv = 0;
        tick();
        check("small_drained", 32'(s_ov), 32'd0);

        // asynchronous reset while full
        ordy = 0; iv = 1; din = $urandom();
        tick();
        din = $urandom();
        tick();
        check("pre_rst_full", 32'(data_in_0_ready), 32'd0);
        #2;
        sb_on = 0;
        rst = 1;
        #1;
        check("arst_out_valid", 32'(data_out_0_valid), 32'd0);
        check("arst_in_ready", 32'(data_in_0_ready), 32'd1);
        check("arst_sat", 32'(sat_count), 32'd0);
        exp_q.delete();
        model_sat = '0;
        iv = 0;
        tick();
        rst = 0;
        din = 32'h0100FD05; iv = 1; ordy = 1; sb_on = 1;
        tick();
        check("post_rst_valid", 32'(data_out_0_valid), 32'd1);
        check("post_rst_data", 32'(data_out_0), 32'({5'd1, 5'd0, 5'b11111, 5'd3}));
        iv = 0;
        tick();

        // random traffic on both sides
        n_acc = 0;
        for (int c = 0; c < 40000 && n_acc < 10000; c++) begin
            iv   = $urandom_range(0, 3) != 0;
            ordy = $urandom_range(0, 3) != 0;
            clr  = $urandom_range(0, 99) == 0;
            din  = $urandom();
            tick();
        end
        check("rand_beat_count", 32'(n_acc >= 10000), 32'd1);
        iv = 0; clr = 0; ordy = 1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        check("rand_all_delivered", 32'(exp_q.size()), 32'd0);
        check("cov_full", 32'(full_seen > 0), 32'd1);
        check("cov_full_to_one", 32'(full_to_one > 0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fixed_requant_stream.md
# fixed_requant_stream

Streaming requantiser that sits directly upstream of the 5-bit SiLU lookup stage. It converts wide signed fixed-point activations into the narrow signed format the LUT indexes, using round-half-up and saturation. It wraps the conversion in a valid/ready pipeline with a skid buffer, so it runs at full throughput under backpressure. A sticky saturation-event counter lets quantisation clipping be monitored.

## Interface
- DATA_IN_0_PRECISION_0, 8: input word width (signed, two's complement).
- DATA_IN_0_PRECISION_1, 3: input fractional bits.
- DATA_OUT_0_PRECISION_0, 5: output word width (signed); matches the LUT index width.
- DATA_OUT_0_PRECISION_1, 2: output fractional bits; must be ≤ DATA_IN_0_PRECISION_1 (elaboration error otherwise).
- PARALLELISM, 4: lanes per beat.
- SAT_CNT_WIDTH, 16: saturation counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- data_in_0  in  [PARALLELISM] x DATA_IN_0_PRECISION_0  input lanes.
- data_in_0_valid  in  1  upstream beat valid.
- data_in_0_ready  out  1  block can accept a beat.
- data_out_0  out  [PARALLELISM] x DATA_OUT_0_PRECISION_0  requantised lanes, to the LUT.
- data_out_0_valid  out  1  output beat valid.
- data_out_0_ready  in  1  downstream accepts.
- sat_clear  in  1  synchronous clear of sat_count.
- sat_count  out  SAT_CNT_WIDTH  beats with at least one clipped lane.

## Operation
- Define SHIFT = DATA_IN_0_PRECISION_1 − DATA_OUT_0_PRECISION_1.
- Per lane, intermediate width is DATA_IN_0_PRECISION_0+1 bits, sign-extended so the rounding add cannot wrap.
- Rounding:
  - SHIFT > 0: t = (x + 2^(SHIFT−1)) >>> SHIFT. This is round-half-toward-+inf.
  - SHIFT = 0: t = x.
- Saturation: clamp t to [−2^(W−1), 2^(W−1)−1], where W = DATA_OUT_0_PRECISION_0. A lane is clipped if the clamp changed its value.
- The beat-level `clipped` flag is the OR over all lanes. It is computed at acceptance and stored alongside the data.
- Storage is a main output register (out_reg, valid bit) plus one skid register (skid_reg, valid bit).
- States, encoded by the two valid bits:
  - EMPTY: neither valid.
  - ONE: out_reg only.
  - FULL: out_reg and skid_reg.
- data_in_0_ready = !skid_valid. It is registered-state only, with no combinational path from data_out_0_ready.
- Accept (in_valid & in_ready) and drain (out_valid & out_ready):
  - EMPTY + accept → ONE.
  - ONE + accept + drain → ONE, out_reg ← new beat.
  - ONE + accept, no drain → FULL, skid_reg ← new beat.
  - ONE + drain, no accept → EMPTY.
  - FULL + drain → ONE, out_reg ← skid_reg.
  - FULL never accepts.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- sat_count increments by 1 per accepted beat with `clipped` set. It saturates at all-ones and never wraps.
- sat_clear has priority over a same-cycle increment; the result is 0.
- Payload registers need no reset; only the valid bits and sat_count are reset.

## Timing
- Reset values: data_out_0_valid=0, data_in_0_ready=1, sat_count=0, data_out_0 = don't-care (bench must ignore while invalid).
- Reset mid-operation discards both held beats immediately (asynchronous). Accepting resumes on the first edge after rst falls.
- Latency: a beat accepted at edge k appears on data_out_0 with valid=1 after edge k. This is 1 cycle when the output is empty or draining.
- Throughput is 1 beat/cycle while data_out_0_ready=1.
- data_in_0_ready falls on the edge after the first stalled accept (ONE → FULL). It rises on the edge after a drain from FULL.
- Data and valid are held stable while valid=1 and ready=0.

## Structure
- Shared package fixed_requant_pkg holds:
  - the SHIFT computation function;
  - a state enum {EMPTY, ONE, FULL} used for assertions and coverage;
  - a lane round/saturate function returning {value, clipped}.
- One natural sub-module, fixed_round_sat_lane: combinational, one lane. It is instantiated PARALLELISM times inside a generate loop.
- The handshake and skid logic stay in the top level.

## Test plan
Defaults throughout: 8-bit, frac 3 → 5-bit, frac 2, so SHIFT = 1.
- Lane values 8'sd5, −8'sd3, 8'sd0, 8'sd1 → 5'sd3, −5'sd1 (5'b11111), 5'sd0, 5'sd1; sat_count stays 0.
- Lanes 8'sd40, −8'sd100, 8'sd127, −8'sd128 → 5'sd15, −5'sd16, 5'sd15 (no wrap on 127+1), −5'sd16; sat_count=1.
- Continuous valid with data_out_0_ready low for 3 cycles:
  - data_in_0_ready drops after exactly 1 extra beat;
  - after release, all beats 0..N arrive in order, none dropped or duplicated, at 1/cycle.
- sat_count preloaded to 0xFFFF via forced clipping beats, then another clipping beat → stays 0xFFFF. Then sat_clear together with a clipping beat → 0.
- rst asserted while FULL:
  - data_out_0_valid=0 and data_in_0_ready=1 without waiting for a clock edge;
  - the first beat after release emerges 1 cycle after acceptance.
- Random valid/ready on both sides for 10k beats against a golden model → exact match; the FULL state and the FULL→ONE transition are both covered.
